rf_wport_arbiter: RTL

Write-port arbiter and pending-write scoreboard for the 32×32 register file. Shares the single regfile write port between the in-order pipeline writeback stage and a long-latency unit (mul/div/uncached load) whose results are buffered in a small FIFO. It also tracks registers with outstanding long-latency writes so decode can stall on RAW/WAW hazards. It sits between the WB stage / long-latency unit and the regfile write port (`we`/`wa`/`wd`).

---
 rtl/rf_wport_arbiter_pkg.sv | 30 +++
 rtl/rf_wb_fifo.sv | 47 ++++
 rtl/rf_wport_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants and types for the regfile write-port arbiter.
// RF_ARB_CNT_W bounds STARVE_LIMIT (must be <= 2**RF_ARB_CNT_W).
package rf_wport_arbiter_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_BUS      = 32;
  localparam int REG_NUM      = 32;
  localparam int RF_ARB_CNT_W = 8;

  localparam logic [REG_BUS-1:0] ZERO_WORD    = '0;
  localparam logic               WRITE_ENABLE = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_BUS-1:0] wa;
    logic [REG_BUS-1:0]      wd;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LU   = 2'd2
  } gnt_e;

  function automatic logic addr_hit(input logic we,
                                    input logic [REG_ADDR_BUS-1:0] wa,
                                    input logic [REG_ADDR_BUS-1:0] ra);
    return we && (wa == ra);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering long-latency results for the regfile write port.
module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: WB pass-through, buffered long-latency results,
// starvation hold and pending-write scoreboard. Option: RF_ARB_EARLY_CLEAR_EN.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    cpu_clk_50M,
  input  logic                    cpu_rst,
  input  logic                    wb_we,
  input  logic [REG_ADDR_BUS-1:0] wb_wa,
  input  logic [REG_BUS-1:0]      wb_wd,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [REG_ADDR_BUS-1:0] lu_wa,
  input  logic [REG_BUS-1:0]      lu_wd,
  input  logic                    issue_valid,
  input  logic [REG_ADDR_BUS-1:0] issue_wa,
  input  logic [REG_ADDR_BUS-1:0] ra1,
  input  logic [REG_ADDR_BUS-1:0] ra2,
  output logic                    busy1,
  output logic                    busy2,
  output logic                    busy_d,
  output logic                    starve_hold,
  output logic                    rf_we,
  output logic [REG_ADDR_BUS-1:0] rf_wa,
  output logic [REG_BUS-1:0]      rf_wd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RF_ARB_CNT_W-1:0] CNT_LAST = RF_ARB_CNT_W'(STARVE_LIMIT - 1);

  rf_wr_t                  head;
  rf_wr_t                  din;
  logic [$bits(rf_wr_t)-1:0] head_bits;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    blocked;
  gnt_e                    gnt;
  logic [RF_ARB_CNT_W-1:0] starve_cnt;
  logic [REG_NUM-1:1]      busy_q;
  logic [REG_NUM-1:0]      busy_vec;

  assign lu_ready = (count != CW'(FIFO_DEPTH)) && !cpu_rst;
  assign push     = lu_valid && !full && !cpu_rst;
  assign din      = '{wa: lu_wa, wd: lu_wd};
  assign head     = rf_wr_t'(head_bits);

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(rf_wr_t))
  ) u_fifo (
    .clk   (cpu_clk_50M),
    .rst   (cpu_rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head_bits),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // WB always wins when it writes; under starve_hold WB is expected to be idle,
  // so the head is granted. A WB write during the hold is still honoured.
  always_comb begin
    gnt = GNT_NONE;
    if (wb_we)       gnt = GNT_WB;
    else if (!empty) gnt = GNT_LU;
  end

  assign pop     = (gnt == GNT_LU);
  assign blocked = !empty && !pop;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = wb_wa;
    rf_wd = ZERO_WORD;
    unique case (gnt)
      GNT_WB: begin
        rf_we = WRITE_ENABLE;
        rf_wa = wb_wa;
        rf_wd = wb_wd;
      end
      GNT_LU: begin
        // x0 results are dropped but still leave the FIFO.
        rf_we = (head.wa != '0);
        rf_wa = head.wa;
        rf_wd = head.wd;
      end
      default: ;
    endcase
    if (cpu_rst) rf_we = 1'b0;
  end

  // Counter saturates at the last value; the hold then forces the next pop.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      starve_cnt  <= '0;
      starve_hold <= 1'b0;
    end else if (!blocked) begin
      starve_cnt  <= '0;
      starve_hold <= 1'b0;
    end else if (starve_cnt == CNT_LAST) begin
      starve_hold <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  for (genvar i = 1; i < REG_NUM; i++) begin : g_busy
    always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst)
        busy_q[i] <= 1'b0;
      else if (issue_valid && issue_wa == REG_ADDR_BUS'(i))
        busy_q[i] <= 1'b1;
      else if (pop && head.wa == REG_ADDR_BUS'(i))
        busy_q[i] <= 1'b0;
    end
  end

  assign busy_vec = {busy_q, 1'b0};
  assign busy_d   = busy_vec[issue_wa];

`ifdef RF_ARB_EARLY_CLEAR_EN
  // Release in the write cycle; the regfile forwards the written value.
  assign busy1 = busy_vec[ra1] & !addr_hit(rf_we, rf_wa, ra1);
  assign busy2 = busy_vec[ra2] & !addr_hit(rf_we, rf_wa, ra2);
`else
  assign busy1 = busy_vec[ra1];
  assign busy2 = busy_vec[ra2];
`endif

endmodule
